// File: rtl/escalator_seq_ctrl.sv
// escalator_seq_ctrl: motor sequencer for the escalator.
// Chooses travel direction from the landing sensors. Ramps the speed code up
// and down one step per time-base tick. Holds run speed while the entry
// sensor shows traffic. Waits a dwell period before accepting the next trip.
// Emergency stop latches the FAULT state until it is acknowledged.
// Optional feature macro: ESC_TRIP_COUNT_EN. When it is defined, trips counts
// IDLE->RAMP_UP starts and saturates at 255. When it is undefined, trips is 0.
module escalator_seq_ctrl #(
    parameter int SPEED_W     = 4,
    parameter int MAX_SPEED   = 12,
    parameter int IDLE_TICKS  = 20,
    parameter int DWELL_TICKS = 5,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               sens_bot,
    input  logic               sens_top,
    input  logic               estop,
    input  logic               fault_clr,
    output logic               motor_en,
    output logic               dir,
    output logic [SPEED_W-1:0] speed,
    output logic [2:0]         state,
    output logic               fault,
    output logic [7:0]         trips
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_RUN       = 3'd2,
        ST_RAMP_DN   = 3'd3,
        ST_STOP_WAIT = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    localparam logic [SPEED_W-1:0] SPD_MAX   = SPEED_W'(MAX_SPEED);
    localparam logic [SPEED_W-1:0] SPD_PRE   = SPEED_W'(MAX_SPEED - 1);
    localparam logic [SPEED_W-1:0] SPD_ONE   = SPEED_W'(1);
    localparam logic [SPEED_W-1:0] SPD_ZERO  = SPEED_W'(0);
    localparam logic [CNT_W-1:0]   CNT_IDLE  = CNT_W'(IDLE_TICKS);
    localparam logic [CNT_W-1:0]   CNT_DWELL = CNT_W'(DWELL_TICKS);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ZERO  = CNT_W'(0);

    state_t             state_r, next_state_s;
    logic [SPEED_W-1:0] speed_r, next_speed_s;
    logic [CNT_W-1:0]   cnt_r, next_cnt_s;
    logic               dir_r, next_dir_s;
    logic               motor_en_r, fault_r;
    logic               entry_s;
    logic               next_motor_en_s, next_fault_s;

    // The entry landing is the one passengers board from in the current direction.
    assign entry_s = dir_r ? sens_bot : sens_top;

    // Next-state, speed, counter and direction decode. estop overrides every state.
    always_comb begin
        next_state_s = state_r;
        next_speed_s = speed_r;
        next_cnt_s   = cnt_r;
        next_dir_s   = dir_r;
        if (estop) begin
            next_state_s = ST_FAULT;
            next_speed_s = SPD_ZERO;
            next_cnt_s   = CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    next_speed_s = SPD_ZERO;
                    if (sens_bot) begin
                        next_dir_s   = 1'b1;
                        next_state_s = ST_RAMP_UP;
                    end else if (sens_top) begin
                        next_dir_s   = 1'b0;
                        next_state_s = ST_RAMP_UP;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
                ST_RAMP_UP: begin
                    // A re-entry from RAMP_DN can arrive at full speed, so clamp.
                    if (tick) begin
                        if (speed_r >= SPD_PRE) begin
                            next_speed_s = SPD_MAX;
                            next_state_s = ST_RUN;
                            next_cnt_s   = CNT_ZERO;
                        end else begin
                            next_speed_s = speed_r + SPD_ONE;
                        end
                    end else begin
                        next_speed_s = speed_r;
                    end
                end
                ST_RUN: begin
                    next_speed_s = SPD_MAX;
                    if (entry_s) begin
                        next_cnt_s = CNT_ZERO;
                    end else if (tick) begin
                        if ((cnt_r + CNT_ONE) == CNT_IDLE) begin
                            next_state_s = ST_RAMP_DN;
                            next_cnt_s   = CNT_ZERO;
                        end else begin
                            next_cnt_s = cnt_r + CNT_ONE;
                        end
                    end else begin
                        next_cnt_s = cnt_r;
                    end
                end
                ST_RAMP_DN: begin
                    if (entry_s) begin
                        next_state_s = ST_RAMP_UP;
                    end else if (tick) begin
                        if (speed_r <= SPD_ONE) begin
                            next_speed_s = SPD_ZERO;
                            next_state_s = ST_STOP_WAIT;
                            next_cnt_s   = CNT_ZERO;
                        end else begin
                            next_speed_s = speed_r - SPD_ONE;
                        end
                    end else begin
                        next_speed_s = speed_r;
                    end
                end
                ST_STOP_WAIT: begin
                    next_speed_s = SPD_ZERO;
                    if (tick) begin
                        if ((cnt_r + CNT_ONE) == CNT_DWELL) begin
                            next_state_s = ST_IDLE;
                            next_cnt_s   = CNT_ZERO;
                        end else begin
                            next_cnt_s = cnt_r + CNT_ONE;
                        end
                    end else begin
                        next_cnt_s = cnt_r;
                    end
                end
                ST_FAULT: begin
                    next_speed_s = SPD_ZERO;
                    if (fault_clr) begin
                        next_state_s = ST_STOP_WAIT;
                        next_cnt_s   = CNT_ZERO;
                    end else begin
                        next_state_s = ST_FAULT;
                    end
                end
                default: begin
                    next_state_s = ST_FAULT;
                    next_speed_s = SPD_ZERO;
                    next_cnt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // Output flags are decoded from the next state so that they are registered alongside it.
    always_comb begin
        next_motor_en_s = 1'b0;
        next_fault_s    = 1'b0;
        case (next_state_s)
            ST_RAMP_UP, ST_RUN, ST_RAMP_DN: next_motor_en_s = 1'b1;
            ST_FAULT:                       next_fault_s    = 1'b1;
            default: begin
                next_motor_en_s = 1'b0;
                next_fault_s    = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            speed_r    <= SPD_ZERO;
            cnt_r      <= CNT_ZERO;
            dir_r      <= 1'b1;
            motor_en_r <= 1'b0;
            fault_r    <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            speed_r    <= next_speed_s;
            cnt_r      <= next_cnt_s;
            dir_r      <= next_dir_s;
            motor_en_r <= next_motor_en_s;
            fault_r    <= next_fault_s;
        end
    end

    assign state    = state_r;
    assign speed    = speed_r;
    assign dir      = dir_r;
    assign motor_en = motor_en_r;
    assign fault    = fault_r;

`ifdef ESC_TRIP_COUNT_EN
    logic [7:0] trips_r;
    logic       start_s;

    assign start_s = (state_r == ST_IDLE) && (next_state_s == ST_RAMP_UP);

    // Count trip starts and hold at 255. Only rst clears the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trips_r <= 8'd0;
        end else if (start_s && (trips_r != 8'd255)) begin
            trips_r <= trips_r + 8'd1;
        end else begin
            trips_r <= trips_r;
        end
    end

    assign trips = trips_r;
`else
    assign trips = 8'd0;
`endif

endmodule
